// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-master arbiter/sequencer in front of a single-port data memory.
//
// Master 0 is the CPU load/store stage, master 1 a DMA/peripheral port. One
// request is latched at a time, checked for range (< ADDR_LIMIT) and word
// alignment, and the memory strobe is driven for exactly one cycle. The owning
// master receives a one-cycle ack together with read data and an error flag.
//
// Flow: IDLE -(any req)-> ACCESS -> RESP -> IDLE. Request sampled at edge E,
// memory access during cycle E+1, ack during cycle E+2.
//
// Ports:
//   clk, reset                         clock, async active-high reset
//   mX_req/mX_wr/mX_addr/mX_wdata      master X request (X = 0,1)
//   mX_ack/mX_rdata/mX_err             master X one-cycle response
//   mem_rd/mem_wr/mem_addr/mem_wdata   memory strobes and latched address/data
//   mem_rdata                          combinational memory read data
//   busy                               high in ACCESS and RESP
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> master 0 always wins a tie
//                           undefined -> round-robin on ties (default)

module dmem_arbiter #(
  parameter int ADDR_LIMIT = 256,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              owner;     // 0 = master 0, 1 = master 1
  logic              winner;
  logic              wr_l;
  logic [DATA_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              bad;

  // Arbitration: a lone requester always wins; only ties consult the policy.
`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~m0_req & m1_req;
  end
`else
  logic last_grant;

  always_comb begin
    if (m0_req && m1_req) winner = ~last_grant;
    else                  winner = ~m0_req & m1_req;
  end

  // Reset to 1 so master 0 takes the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              last_grant <= 1'b1;
    else if (state == RESP) last_grant <= owner;
  end
`endif

  // Range/alignment check works only from latched registers, so the strobes
  // below never glitch with master inputs.
  assign bad = (addr_l >= DATA_W'(ADDR_LIMIT)) || (addr_l[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_rd    = ~bad & ~wr_l;
        mem_wr    = ~bad &  wr_l;
        state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        state_nxt = IDLE;
        if (owner) begin
          m1_ack   = 1'b1;
          m1_rdata = rdata_q;
          m1_err   = err_q;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = rdata_q;
          m0_err   = err_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = addr_l;
  assign mem_wdata = wdata_l;

  // Request latch and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= 1'b0;
      wr_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && (m0_req || m1_req)) begin
        owner   <= winner;
        wr_l    <= winner ? m1_wr    : m0_wr;
        addr_l  <= winner ? m1_addr  : m0_addr;
        wdata_l <= winner ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS) begin
        // Writes and rejected accesses return zero data.
        rdata_q <= (!wr_l && !bad) ? mem_rdata : '0;
        err_q   <= bad;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port data memory.
- Master 0 is the CPU load/store stage; master 1 is a DMA/peripheral port.
- Latches one request at a time, range/alignment-checks it, and drives the memory strobes for exactly one cycle.
- Returns read data, an error flag and a one-cycle ack to the owning master; round-robin fairness by default.

Parameters:
- ADDR_LIMIT, 256, byte-address bound. Addresses >= ADDR_LIMIT are rejected with err.
- DATA_W, 32, data and address width. Fixed at 32 in this design.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous active-high reset.
- m0_req  input  1  master 0 request; held high until m0_ack is seen.
- m0_wr  input  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  input  32  master 0 byte address; must be word aligned.
- m0_wdata  input  32  master 0 write data.
- m0_ack  output  1  one-cycle completion pulse to master 0.
- m0_rdata  output  32  master 0 read data; valid while m0_ack=1.
- m0_err  output  1  master 0 range/alignment error; valid while m0_ack=1.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as master 0, for master 1.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe; the memory writes on posedge.
- mem_addr  output  32  latched byte address to memory.
- mem_wdata  output  32  latched write data to memory.
- mem_rdata  input  32  combinational read data from memory.
- busy  output  1  high in ACCESS and RESP.

Behaviour:
- State machine: IDLE -> ACCESS -> RESP -> IDLE, unconditionally, except the IDLE exit.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose a winner, latch its wr/addr/wdata into internal registers, set owner, go to ACCESS.
- Arbitration (IDLE only):
  - Single request wins.
  - Both requesting: the master not equal to last_grant wins.
  - last_grant updates to owner on the RESP cycle.
- ACCESS:
  - bad = (addr_l >= ADDR_LIMIT) or (addr_l[1:0] != 0). Evaluated combinationally from the latched registers.
  - If bad: mem_rd=0, mem_wr=0.
  - Else: mem_rd = ~wr_l, mem_wr = wr_l.
  - On the exiting edge: rdata_q <= (read && !bad) ? mem_rdata : 0; err_q <= bad.
  - Go to RESP.
- RESP:
  - mX_ack=1 for owner only; mX_rdata = rdata_q, mX_err = err_q for owner.
  - Non-owner rdata/err = 0.
  - Go to IDLE.
- mem_addr and mem_wdata always show the latched registers. Strobes are decoded only from registered state, so they are glitch-free.
- Latency:
  - Request sampled at edge E; memory access during cycle E+1; ack during cycle E+2.
  - Requester drops req on the edge that samples ack.
  - Back-to-back throughput is one transaction per 3 cycles.
- Boundary conditions:
  - req still high in IDLE after ack (master did not drop it in time): treated as a new request.
  - req dropped during ACCESS/RESP: the latched transaction still completes and ack still pulses.
  - Requests arriving during ACCESS/RESP wait until the next IDLE.
  - Write with bad address: no memory write; ack with err=1.
  - Read with bad address: rdata=0, err=1.
- Reset (asynchronous, any state, including mid-ACCESS):
  - state=IDLE, last_grant=1 (master 0 wins the first tie).
  - addr_l=0, wdata_l=0, wr_l=0, rdata_q=0, err_q=0.
  - All outputs 0: acks, errs, rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy.
  - An in-flight write is aborted; mem_wr falls asynchronously with reset.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins ties; last_grant is unused and has no effect.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read: m0 read addr 0x10, memory word 4 = 0xDEADBEEF -> mem_rd high one cycle at E+1; m0_ack high at E+2 with m0_rdata=0xDEADBEEF, m0_err=0.
- Write then read: m1 writes 0x12345678 to 0x20 -> mem_wr high exactly one cycle, mem_addr=0x20; then m1 reads 0x20 -> m1_rdata=0x12345678.
- Tie, round-robin: both masters request continuously from reset -> acks alternate m0, m1, m0, m1, spaced 3 cycles apart. With DMEM_ARB_FIXED_PRIO_EN -> m0 acked every time while m0_req stays high.
- Error cases, each acked with err=1 and no memory strobe:
  - m0 write to 0x100 (ADDR_LIMIT=256): mem_wr stays 0.
  - m1 read of 0x22: rdata=0.
- Async reset in ACCESS during a write: mem_wr falls immediately; no ack is issued; after release, the next tie goes to m0.
- Req dropped during ACCESS: m0 deasserts req one cycle after it is sampled -> m0_ack still pulses at E+2 with correct data.
